// File: rtl/mem_req_ctrl_pkg.sv
// mem_req_ctrl_pkg: controller state encoding shared by mem_req_ctrl and its bench
package mem_req_ctrl_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {CLEAR, IDLE, READ, RESP} state_t;
endpackage

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: request/response channel plus sync_mem pins of mem_req_ctrl
interface mem_req_ctrl_if #(parameter int DEPTH = 4, parameter int WIDTH = 8);
    logic             reqValid;
    logic             reqReady;
    logic             reqWrite;
    logic [DEPTH-1:0] reqAddr;
    logic [WIDTH-1:0] reqData;
    logic             rspValid;
    logic             rspReady;
    logic [WIDTH-1:0] rspData;
    logic             busy;
    logic             memWriteEnable;
    logic [DEPTH-1:0] memAddress;
    logic [WIDTH-1:0] memWriteData;
    logic [WIDTH-1:0] memReadData;
    modport master (
        output reqValid, reqWrite, reqAddr, reqData, rspReady, memReadData,
        input  reqReady, rspValid, rspData, busy, memWriteEnable, memAddress, memWriteData
    );
    modport slave (
        input  reqValid, reqWrite, reqAddr, reqData, rspReady, memReadData,
        output reqReady, rspValid, rspData, busy, memWriteEnable, memAddress, memWriteData
    );
endinterface

// File: rtl/sync_mem.sv
// sync_mem: single-port memory, write when writeEnable else registered read of address
module sync_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             writeEnable,
    input  logic [DEPTH-1:0] address,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] readData
);
    logic [WIDTH-1:0] mem_q [2**DEPTH];
    always_ff @(posedge clock) begin
        if (writeEnable) mem_q[address] <= writeData;
        else readData <= mem_q[address];
    end
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: valid/ready request stream to single-cycle sync_mem commands with held read response.
// MEM_REQ_CTRL_CLEAR_EN adds a post-reset zero-fill sweep of the whole memory.
module mem_req_ctrl
    import mem_req_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input logic           clock,
    input logic           resetN,
    mem_req_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] rsp_data_q;
    logic [DEPTH-1:0] clr_q;
    logic             accept;
`ifdef MEM_REQ_CTRL_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) clr_q <= '0;
        else if (state_q == CLEAR) clr_q <= clr_q + 1'b1;
    end
`else
    localparam state_t RST_STATE = IDLE;
    assign clr_q = '0;
`endif
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= RST_STATE;
            rsp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == READ) rsp_data_q <= bus.memReadData;
        end
    end
    assign accept = bus.reqValid && bus.reqReady;
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLEAR:   state_d = (clr_q == '1) ? IDLE : CLEAR;
            IDLE:    state_d = (accept && !bus.reqWrite) ? READ : IDLE;
            READ:    state_d = RESP;
            RESP:    state_d = !bus.rspReady ? RESP : (accept && !bus.reqWrite) ? READ : IDLE;
            default: state_d = RST_STATE;
        endcase
    end
    // the sweep owns the memory pins while clearing; otherwise they mirror the accepted request
    always_comb begin
        bus.reqReady       = (state_q == IDLE) || (state_q == RESP && bus.rspReady);
        bus.rspValid       = state_q == RESP;
        bus.rspData        = rsp_data_q;
        bus.busy           = state_q != IDLE;
        bus.memWriteEnable = (state_q == CLEAR) || (accept && bus.reqWrite);
        bus.memAddress     = (state_q == CLEAR) ? clr_q : accept ? bus.reqAddr : '0;
        bus.memWriteData   = (accept && bus.reqWrite && state_q != CLEAR) ? bus.reqData : '0;
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: directed and random traffic against a transaction-level memory/response model
module tb_mem_req_ctrl;
    typedef struct {
        logic [7:0] data;
        bit         known;
        int         cyc;
    } rsp_t;
`ifdef MEM_REQ_CTRL_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif
    logic clk, rst_n;
    mem_req_ctrl_if #(.DEPTH(4), .WIDTH(8)) bus ();
    mem_req_ctrl #(.DEPTH(4), .WIDTH(8)) dut (.clock(clk), .resetN(rst_n), .bus(bus));
    sync_mem #(.DEPTH(4), .WIDTH(8)) mem (
        .clock(clk), .writeEnable(bus.memWriteEnable), .address(bus.memAddress),
        .writeData(bus.memWriteData), .readData(bus.memReadData)
    );
    int         checks = 0, failures = 0, cyc = 0, clear_left = 0;
    logic [7:0] model [16];
    bit         known [16];
    rsp_t       q [$];
    logic [7:0] last;
    bit         last_known, acc;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask
    task automatic step(input logic v, input logic w, input logic [3:0] a, input logic [7:0] d, input logic rr);
        bit rv, rdy;
        bus.reqValid = v; bus.reqWrite = w; bus.reqAddr = a; bus.reqData = d; bus.rspReady = rr;
        #1;
        acc = 0;
        if (clear_left > 0) begin
            chk("clr_busy", bus.busy, 1);
            chk("clr_ready", bus.reqReady, 0);
            chk("clr_rsp_valid", bus.rspValid, 0);
            chk("clr_we", bus.memWriteEnable, 1);
            chk("clr_addr", bus.memAddress, 32'(16 - clear_left));
            chk("clr_wdata", bus.memWriteData, 0);
            clear_left--;
        end else begin
            rv  = q.size() != 0 && cyc >= q[0].cyc + 2;
            rdy = q.size() == 0 || (rv && rr);
            chk("rsp_valid", bus.rspValid, rv);
            chk("req_ready", bus.reqReady, rdy);
            chk("busy", bus.busy, q.size() != 0);
            if (rv && q[0].known) chk("rsp_data", bus.rspData, q[0].data);
            if (!rv && last_known) chk("rsp_hold", bus.rspData, last);
            if (rv && rr) begin
                last = q[0].data;
                last_known = q[0].known;
                void'(q.pop_front());
            end
            acc = v && rdy;
            if (acc && w) begin
                chk("wr_we", bus.memWriteEnable, 1);
                chk("wr_addr", bus.memAddress, a);
                chk("wr_data", bus.memWriteData, d);
                model[a] = d;
                known[a] = 1;
            end else if (acc) begin
                chk("rd_we", bus.memWriteEnable, 0);
                chk("rd_addr", bus.memAddress, a);
                q.push_back('{model[a], known[a], cyc});
            end else begin
                chk("idle_we", bus.memWriteEnable, 0);
                chk("idle_addr", bus.memAddress, 0);
                chk("idle_wdata", bus.memWriteData, 0);
            end
        end
        cyc++;
        @(negedge clk);
    endtask
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, input logic rr);
        int n = 0;
        acc = 0;
        while (!acc && n < 20) begin
            step(1, w, a, d, rr);
            n++;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask
    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, rr);
    endtask
    task automatic do_reset();
        bus.reqValid = 0; bus.rspReady = 0;
        rst_n = 0;
        #1;
        chk("rst_rsp_valid", bus.rspValid, 0);
        chk("rst_rsp_data", bus.rspData, 0);
        chk("rst_busy", bus.busy, CLR);
        chk("rst_ready", bus.reqReady, !CLR);
        chk("rst_we", bus.memWriteEnable, CLR);
        chk("rst_addr", bus.memAddress, 0);
        q.delete();
        last = 0;
        last_known = 1;
        clear_left = CLR ? 16 : 0;
        if (CLR) for (int i = 0; i < 16; i++) begin
            model[i] = 0;
            known[i] = 1;
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask
    initial begin
        for (int i = 0; i < 16; i++) begin
            model[i] = 0;
            known[i] = 0;
        end
        rst_n = 0;
        bus.reqValid = 0; bus.reqWrite = 0; bus.reqAddr = 0; bus.reqData = 0; bus.rspReady = 0;
        @(negedge clk);
        do_reset();
        idle(18, 1);
        issue(0, 5, 0, 1);
        idle(3, 1);
        issue(1, 1, 8'h11, 1);
        issue(1, 2, 8'h22, 1);
        issue(1, 3, 8'hA5, 1);
        issue(0, 3, 0, 1);
        idle(3, 1);
        issue(0, 7, 0, 0);
        idle(6, 0);
        idle(2, 1);
        issue(0, 1, 0, 1);
        issue(0, 2, 0, 1);
        idle(3, 1);
        issue(1, 15, 8'hFF, 1);
        issue(0, 0, 0, 1);
        issue(0, 15, 0, 1);
        idle(3, 1);
        for (int i = 0; i < 600; i++)
            step($urandom_range(3) != 0, $urandom_range(1) == 1, 4'($urandom_range(15)),
                 8'($urandom_range(255)), $urandom_range(3) != 0);
        idle(3, 1);
        issue(0, 4, 0, 0);
        idle(3, 0);
        do_reset();
        idle(20, 1);
        issue(0, 3, 0, 1);
        idle(3, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request/response controller sitting directly upstream of `sync_mem`, translating a valid/ready request stream into single-cycle memory commands. It drives `sync_mem`'s write-enable, address and write-data pins and captures its registered read data into a response channel that holds under back-pressure. An optional post-reset sweep zero-fills the whole memory before any request is accepted.

## Interface
- `DEPTH`, 4, address width; memory holds 2**DEPTH words (matches `sync_mem`).
- `WIDTH`, 8, data word width.

- `clock`  in  1  single clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  controller accepts request this cycle.
- `reqWrite`  in  1  1 = write, 0 = read.
- `reqAddr`  in  DEPTH  request address.
- `reqData`  in  WIDTH  write data (ignored for reads).
- `rspValid`  out  1  read response present.
- `rspReady`  in  1  consumer takes response.
- `rspData`  out  WIDTH  read data.
- `busy`  out  1  state is not IDLE.
- `memWriteEnable`  out  1  to `sync_mem.writeEnable`.
- `memAddress`  out  DEPTH  to `sync_mem.address`.
- `memWriteData`  out  WIDTH  to `sync_mem.writeData`.
- `memReadData`  in  WIDTH  from `sync_mem.readData`.

## Operation
- States: CLEAR (only with macro), IDLE, READ, RESP.
- Accept = `reqValid && reqReady`. `reqReady` = (state==IDLE) || (state==RESP && rspReady); 0 in CLEAR and READ.
- Memory-side outputs are combinational from the accepted request: write → `memWriteEnable`=1, `memAddress`=`reqAddr`, `memWriteData`=`reqData`; read → `memWriteEnable`=0, `memAddress`=`reqAddr`. No accept → all three 0.
- Write accept: stays/returns to IDLE; no response generated.
- Read accept: next state READ. In READ, `memReadData` is valid; register it into `rspData`, go to RESP.
- RESP: `rspValid`=1, `rspData` stable until `rspReady`. On `rspReady`: accepted read → READ; accepted write → IDLE (write issued same cycle); no accept → IDLE.
- `rspData` holds last value after handshake; only updated in READ.
- Since `sync_mem` reads every non-write cycle, `memReadData` is sampled only in READ.

## Timing
- Reset values: state = CLEAR (macro) / IDLE, `rspValid`=0, `rspData`=0, clear counter=0; `reqReady`, `busy`, mem outputs follow state.
- Write accepted in cycle N → memory updated at end of cycle N.
- Read accepted in cycle N → `rspValid` high from cycle N+2.
- Read accepted in cycle N+1 after write to same address in cycle N returns the new data.
- Peak read throughput: one read per 2 cycles with `rspReady` held high; a write can be issued in the RESP-exit cycle.
- `rspReady` low: RESP held indefinitely, no requests accepted.
- Reset asserted mid-transaction: pending response dropped, outputs to reset values immediately.

## Configuration
- `MEM_REQ_CTRL_CLEAR_EN` defined: after reset deassertion, CLEAR runs 2**DEPTH cycles, driving `memWriteEnable`=1, `memAddress`=counter (0 to 2**DEPTH-1), `memWriteData`=0; `busy`=1, `reqReady`=0; after address 2**DEPTH-1 → IDLE. Reset during CLEAR restarts from address 0.
- Undefined: CLEAR state and counter absent; reset enters IDLE; memory contents undefined until written.

## Structure
- Package `mem_req_ctrl_pkg`: state enum typedef (`CLEAR`, `IDLE`, `READ`, `RESP`), state width constant.
- No sub-module in the block. Bench instantiates `mem_req_ctrl` plus `sync_mem` with matching DEPTH/WIDTH.

## Test plan
- Reset with macro, DEPTH=4: `busy`=1, `reqReady`=0 for 16 cycles, addresses 0..15 written with 0; read addr 5 → `rspData`=0x00.
- Write 0xA5 to addr 3 (cycle N), read addr 3 (cycle N+1) → `rspValid` at N+3, `rspData`=0xA5.
- Read addr 7 with `rspReady` low 5 cycles → `rspValid`/`rspData` stable, `reqReady`=0 throughout; on `rspReady` single handshake.
- Back-to-back reads addr 1,2 (0x11,0x22) with `rspReady`=1 → responses 0x11 then 0x22, second read accepted in RESP-exit cycle.
- Reset asserted while in RESP → `rspValid` drops immediately, state CLEAR/IDLE, no stale response after release.
- Write 0xFF addr 15 then read addr 0 and 15 → wrap-edge addresses correct (0x00 under macro, 0xFF).
